// File: rtl/dmem_fill_pkg.sv
// Shared L1D line-fill definitions: FSM encoding and default geometry,
// imported by both the fill engine and the L1D.
package dmem_fill_pkg;

  localparam int DMEM_LINE_DEF = 512;
  localparam int BEAT_W_DEF    = 64;
  localparam int BLK_LEN_DEF   = 58;
  localparam int OFFS_DEF      = $clog2(DMEM_LINE_DEF / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_BEAT = 3'd3,
    S_DONE = 3'd4
  } fill_state_e;

endpackage

// File: rtl/dmem_fill.sv
// L1D fill engine: a one-line buffer in front of a burst memory port.
// A hit returns the buffered line; a miss fetches BEATS beats into it.
module dmem_fill
  import dmem_fill_pkg::*;
#(
  parameter int DMEM_LINE = DMEM_LINE_DEF,
  parameter int BEAT_W    = BEAT_W_DEF,
  parameter int BLK_LEN   = BLK_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BLK_LEN-1:0]   b_addr_d,
  input  logic                 b_rd_d,
  output logic [DMEM_LINE-1:0] b_data_in_d,
  output logic                 b_dv_d,
  input  logic [BLK_LEN-1:0]   inv_addr,
  input  logic                 inv,
  output logic [63:0]          m_addr,
  output logic                 m_req,
  input  logic                 m_gnt,
  input  logic [BEAT_W-1:0]    m_rdata,
  input  logic                 m_rvalid
);

  localparam int BEATS = DMEM_LINE / BEAT_W;
  localparam int OFFS  = $clog2(DMEM_LINE / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  fill_state_e          state_q, state_n;
  logic [BLK_LEN-1:0]   blk_q, lb_tag;
  logic                 lb_v, poison_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DMEM_LINE-1:0] lb_data;
  logic                 wait_hit, poison_hit, beat_fire, last_beat;

  // A same-cycle invalidate of the requested block beats the hit.
  assign wait_hit   = lb_v && (lb_tag == b_addr_d) && !(inv && (inv_addr == b_addr_d));
  assign beat_fire  = (state_q == S_BEAT) && m_rvalid;
  assign last_beat  = beat_fire && (cnt_q == CNT_W'(BEATS - 1));
  assign poison_hit = inv && (inv_addr == blk_q) && ((state_q == S_REQ) || (state_q == S_BEAT));

  assign m_req       = (state_q == S_REQ);
  assign b_dv_d      = (state_q == S_DONE) && b_rd_d;
  assign m_addr      = 64'({blk_q, {OFFS{1'b0}}});
  assign b_data_in_d = lb_data;

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (b_rd_d) state_n = S_WAIT;
      S_WAIT:  state_n = wait_hit ? S_DONE : S_REQ;
      S_REQ:   if (m_gnt) state_n = S_BEAT;
      S_BEAT:  if (last_beat) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      blk_q    <= '0;
      lb_tag   <= '0;
      lb_v     <= 1'b0;
      poison_q <= 1'b0;
      cnt_q    <= '0;
      lb_data  <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == S_WAIT) blk_q <= b_addr_d;

      if ((state_q == S_REQ) && m_gnt) cnt_q <= '0;
      else if (beat_fire)              cnt_q <= cnt_q + CNT_W'(1);

      if (state_n == S_IDLE) poison_q <= 1'b0;
      else if (poison_hit)   poison_q <= 1'b1;

      // The final beat installs the new tag, so it overrides a clear aimed at the old one.
      if (inv && (inv_addr == lb_tag)) lb_v <= 1'b0;
      if (last_beat) begin
        lb_tag <= blk_q;
        lb_v   <= !(poison_q || poison_hit);
      end

      if (beat_fire)
        for (int b = 0; b < BEATS; b++)
          if (cnt_q == CNT_W'(b)) lb_data[b*BEAT_W +: BEAT_W] <= m_rdata;
    end
  end

endmodule
